// File: rtl/sys_array_ctrl_if.sv
// Bundle of job, input-stream, array and result signals around the systolic array sequencer.
// master is the sequencer's view; slave is the host/array side.
interface sys_array_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_L  = 4,
  parameter int ARRAY_W_L  = 4,
  parameter int CNT_W      = 16
);
  logic                                       start;
  logic [CNT_W-1:0]                           num_vec;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0]       in_data;
  logic                                       arr_weights_load;
  logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0]       arr_input_data;
  logic [ARRAY_W_L-1:0][2*DATA_WIDTH-1:0]     arr_output_data;
  logic                                       out_valid;
  logic [ARRAY_W_L-1:0][2*DATA_WIDTH-1:0]     out_data;
  logic                                       busy;
  logic                                       done;

  modport master (
    input  start, num_vec, in_valid, in_data, arr_output_data,
    output in_ready, arr_weights_load, arr_input_data, out_valid, out_data, busy, done
  );

  modport slave (
    output start, num_vec, in_valid, in_data, arr_output_data,
    input  in_ready, arr_weights_load, arr_input_data, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/sys_array_ctrl.sv
// Weight-stationary systolic array sequencer: weight-load strobe, input skew,
// valid tagging and output deskew into one aligned result word per accepted vector.
module sys_array_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_L  = 4,
  parameter int ARRAY_W_L  = 4,
  parameter int PIPE_LAT   = 5,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  sys_array_ctrl_if.master  bus
);

  localparam int RW    = 2 * DATA_WIDTH;
  localparam int L_TOT = PIPE_LAT + ARRAY_W_L;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                              r_state;
  logic                                r_in_ready;
  logic                                r_wload;
  logic                                r_busy;
  logic                                r_done;
  logic [CNT_W-1:0]                    r_num_vec;
  logic [CNT_W-1:0]                    r_cnt;
  logic [L_TOT-1:0]                    r_tag;
  logic [ARRAY_W_L-1:0][RW-1:0]        r_out_data;

  logic                                w_accept;
  logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0] w_feed_vec;
  logic [ARRAY_A_L-1:0][DATA_WIDTH-1:0] w_arr_in;
  logic [ARRAY_W_L-1:0][RW-1:0]        w_aligned;

  // in_ready is only ever high in FEED, so it alone qualifies a transfer.
  assign w_accept   = r_in_ready && bus.in_valid;
  assign w_feed_vec = w_accept ? bus.in_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_wload    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_num_vec  <= '0;
      r_cnt      <= '0;
    end else begin
      r_wload <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_num_vec <= bus.num_vec;
            r_cnt     <= '0;
            r_wload   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_num_vec != '0) begin
            r_in_ready <= 1'b1;
            r_state    <= S_FEED;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_FEED: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Compare against num_vec-1 so a full-range count never wraps.
            if (r_cnt == r_num_vec - CNT_W'(1)) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Only the oldest tag may remain: it is producing out_valid right now.
          if (r_tag[L_TOT-2:0] == '0) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[L_TOT-2:0], w_accept};
    end
  end

  genvar gi;

  // Lane k passes through k+1 registers so the array sees the diagonal wavefront.
  generate
    for (gi = 0; gi < ARRAY_A_L; gi++) begin : g_skew
      logic [DATA_WIDTH-1:0] r_pipe [0:gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j <= gi; j++) begin
            r_pipe[j] <= '0;
          end
        end else begin
          r_pipe[0] <= w_feed_vec[gi];
          for (int j = 1; j <= gi; j++) begin
            r_pipe[j] <= r_pipe[j-1];
          end
        end
      end

      assign w_arr_in[gi] = r_pipe[gi];
    end
  endgenerate

  assign bus.arr_input_data = w_arr_in;

  // Column t finishes t cycles after column 0, so it is held back ARRAY_W_L-1-t cycles.
  generate
    for (gi = 0; gi < ARRAY_W_L; gi++) begin : g_deskew
      localparam int D = ARRAY_W_L - 1 - gi;
      if (D == 0) begin : g_direct
        assign w_aligned[gi] = bus.arr_output_data[gi];
      end else begin : g_delay
        logic [RW-1:0] r_dly [0:D-1];

        always_ff @(posedge clk) begin
          if (reset) begin
            for (int j = 0; j < D; j++) begin
              r_dly[j] <= '0;
            end
          end else begin
            r_dly[0] <= bus.arr_output_data[gi];
            for (int j = 1; j < D; j++) begin
              r_dly[j] <= r_dly[j-1];
            end
          end
        end

        assign w_aligned[gi] = r_dly[D-1];
      end
    end
  endgenerate

  // Words without a valid tag are zeroed so bubbles and flushed jobs never leak data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
    end else begin
      r_out_data <= r_tag[L_TOT-2] ? w_aligned : '0;
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.arr_weights_load = r_wload;
  assign bus.out_valid        = r_tag[L_TOT-1];
  assign bus.out_data         = r_out_data;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;

endmodule
